vm_page_table: RTL and testbench
================================

# vm_page_table

Single-level page table for the 12-bit virtual-memory subsystem. It maps an 8-bit virtual page number (VA[11:4], 16-byte pages) to a 6-bit physical page number (PA[9:4]) plus a valid bit. The TLB queries it on a miss and forms PA = {ppn, VA[3:0]}. The table is a 256-entry register array with a combinational lookup port and a clocked update port for the OS/miss handler.

## Interface
- No parameters. Sizes are fixed: 256 entries, 8-bit VPN, 6-bit PPN.
- clk  input  1  system clock; all updates occur on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- vpn  input  8  lookup virtual page number (driven from VA[11:4]).
- ppn  output  6  physical page number stored at entry vpn.
- valid  output  1  entry vpn holds a valid mapping.
- wr_en  input  1  update strobe, sampled on the clk rising edge.
- wr_vpn  input  8  entry index to update.
- wr_ppn  input  6  new PPN for entry wr_vpn.
- wr_valid  input  1  new valid bit for entry wr_vpn; 0 unmaps the page.

## Operation
- Storage: 256 entries, each holding {valid, ppn[5:0]}.
- Reset contents (on rst_n low):
  - Entries 0–63: valid = 1, ppn = entry index (identity map of all 64 frames).
  - Entries 64–255: valid = 0, ppn = 0.
- Lookup is purely combinational: ppn = entry[vpn].ppn and valid = entry[vpn].valid.
- Outputs follow any change on vpn or on the stored entry with no clock involved.
- The ppn output always shows the stored field, even when valid = 0. The consumer qualifies it with valid.
- Update: when wr_en = 1 at a rising edge with rst_n = 1, entry[wr_vpn] ← {wr_valid, wr_ppn}. No other entry changes.
- When wr_en = 0, the table holds its contents.
- Multiple virtual pages may map to the same ppn. No uniqueness check is made.
- No page-fault signalling is generated internally. valid = 0 is the fault indication to the TLB and its handler.

## Timing
- Lookup latency is zero cycles (combinational). The TLB samples ppn/valid within the same cycle, after vpn settles.
- Write latency is one edge. A lookup of wr_vpn returns the old entry up to the edge and the new entry immediately after it. No write-through bypass is provided.
- Simultaneous lookup and write to the same index in one cycle: the output shows the old value until the edge.
- Reset:
  - Takes effect asynchronously. Outputs reflect the reset contents as soon as rst_n falls, independent of clk.
  - Any wr_en in progress while rst_n = 0 is ignored.
  - A write at the first edge after rst_n rises is accepted.
- Index wrap: wr_vpn and vpn are full 8-bit values. All 256 values, 0x00 to 0xFF, address a distinct entry, so out-of-range access cannot occur.

## Test plan
- Reset check: assert rst_n = 0 mid-simulation, then sweep vpn 0x00–0xFF combinationally. Expect vpn 0x00–0x3F → valid = 1, ppn = vpn; vpn 0x40–0xFF → valid = 0, ppn = 0.
- Map a high page: write wr_vpn = 0xA5, wr_ppn = 0x2C, wr_valid = 1. Set vpn = 0xA5. Expect valid = 0, ppn = 0 before the edge, and valid = 1, ppn = 0x2C after the edge. Neighbours 0xA4 and 0xA6 remain unchanged.
- Unmap: write wr_vpn = 0x10, wr_valid = 0, wr_ppn = 0x10. Expect lookup of 0x10 → valid = 0, ppn = 0x10.
- Write disabled: hold wr_en = 0 with wr_vpn = 0x05 and wr_ppn = 0x3F for several edges. Expect lookup of 0x05 to still give ppn = 0x05, valid = 1.
- Async reset mid-operation: after the writes above, pulse rst_n low between clock edges. Expect 0xA5 to read valid = 0 and 0x10 to read valid = 1, ppn = 0x10 before the next edge.
- TLB integration: VA = 0xA53 after mapping 0xA5→0x2C. Expect the TLB to miss, load the entry, and produce PA = 0x2C3 (10-bit {0x2C, 0x3}).

Source files
------------

// File: rtl/vm_page_table.sv
// Purpose: single-level page table, 256 x {valid, ppn[5:0]}, indexed by VA[11:4].
// Latency: combinational lookup (0 cycles); updates land on the rising clk edge.
// Backpressure: none; lookups and writes are always accepted, no stall path.
//
// Ports:
//   clk      - clock; writes commit on its rising edge
//   rst_n    - asynchronous active-low reset, restores the identity map
//   vpn      - lookup index (VA[11:4])
//   ppn      - stored physical page number at entry vpn (shown even if invalid)
//   valid    - entry vpn holds a valid mapping; 0 is the fault indication
//   wr_en    - update strobe
//   wr_vpn   - entry to update
//   wr_ppn   - new physical page number
//   wr_valid - new valid bit (0 unmaps the page)
module vm_page_table (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] vpn,
  output logic [5:0] ppn,
  output logic       valid,
  input  logic       wr_en,
  input  logic [7:0] wr_vpn,
  input  logic [5:0] wr_ppn,
  input  logic       wr_valid
);

  typedef struct packed {
    logic       valid;
    logic [5:0] ppn;
  } pte_t;

  localparam int NUM_ENTRIES = 256;
  // The first 64 pages identity-map every physical frame after reset.
  localparam int NUM_FRAMES  = 64;

  pte_t entry_q [NUM_ENTRIES];

  // Each entry is its own register with an async reset value that depends on
  // its index; the write decode only touches the addressed entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        if (i < NUM_FRAMES) begin
          entry_q[i] <= '{valid: 1'b1, ppn: 6'(i)};
        end else begin
          entry_q[i] <= '{valid: 1'b0, ppn: 6'd0};
        end
      end
    end else if (wr_en) begin
      entry_q[wr_vpn] <= '{valid: wr_valid, ppn: wr_ppn};
    end
  end

  // No write-through bypass: a same-cycle write is visible only after the edge.
  pte_t lookup_pte;
  always_comb begin
    lookup_pte = entry_q[vpn];
    ppn        = lookup_pte.ppn;
    valid      = lookup_pte.valid;
  end

endmodule

// File: tb/tb_vm_page_table.sv
module tb_vm_page_table;

  logic       clk;
  logic       rst_n;
  logic [7:0] vpn;
  logic [5:0] ppn;
  logic       valid;
  logic       wr_en;
  logic [7:0] wr_vpn;
  logic [5:0] wr_ppn;
  logic       wr_valid;

  int checks;
  int errors;

  vm_page_table dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .vpn      (vpn),
    .ppn      (ppn),
    .valid    (valid),
    .wr_en    (wr_en),
    .wr_vpn   (wr_vpn),
    .wr_ppn   (wr_ppn),
    .wr_valid (wr_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [9:0] obs, input logic [9:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Lookup between edges; compares {valid, ppn}.
  task automatic look(input string tag, input logic [7:0] v, input logic exp_valid,
                      input logic [5:0] exp_ppn);
    vpn = v;
    #1;
    check_val(tag, {3'b0, valid, ppn}, {3'b0, exp_valid, exp_ppn});
  endtask

  task automatic do_write(input logic [7:0] v, input logic [5:0] p, input logic val);
    @(negedge clk);
    wr_en    = 1'b1;
    wr_vpn   = v;
    wr_ppn   = p;
    wr_valid = val;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
  endtask

  logic [11:0] va;
  logic [9:0]  pa;

  initial begin
    checks   = 0;
    errors   = 0;
    rst_n    = 1'b0;
    vpn      = 8'h00;
    wr_en    = 1'b0;
    wr_vpn   = 8'h00;
    wr_ppn   = 6'h00;
    wr_valid = 1'b0;

    // Reset contents sweep while held in reset.
    #12;
    for (int i = 0; i < 256; i++) begin
      if (i < 64) look("reset_sweep", 8'(i), 1'b1, 6'(i));
      else        look("reset_sweep", 8'(i), 1'b0, 6'h00);
    end

    @(negedge clk);
    rst_n = 1'b1;

    // Map a high page; old value visible until the edge.
    @(negedge clk);
    vpn      = 8'hA5;
    wr_en    = 1'b1;
    wr_vpn   = 8'hA5;
    wr_ppn   = 6'h2C;
    wr_valid = 1'b1;
    #1;
    check_val("map_a5_before_edge", {3'b0, valid, ppn}, {3'b0, 1'b0, 6'h00});
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    check_val("map_a5_after_edge", {3'b0, valid, ppn}, {3'b0, 1'b1, 6'h2C});
    look("neighbour_a4", 8'hA4, 1'b0, 6'h00);
    look("neighbour_a6", 8'hA6, 1'b0, 6'h00);

    // Unmap keeps the stored ppn visible.
    do_write(8'h10, 6'h10, 1'b0);
    look("unmap_10", 8'h10, 1'b0, 6'h10);

    // Write strobe low: nothing changes.
    @(negedge clk);
    wr_en    = 1'b0;
    wr_vpn   = 8'h05;
    wr_ppn   = 6'h3F;
    wr_valid = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    look("wr_disabled_05", 8'h05, 1'b1, 6'h05);

    // Aliasing: two virtual pages on the same frame.
    do_write(8'hFF, 6'h2C, 1'b1);
    look("alias_ff", 8'hFF, 1'b1, 6'h2C);
    look("alias_a5", 8'hA5, 1'b1, 6'h2C);

    // TLB-style translation of VA 0xA53.
    @(negedge clk);
    va = 12'hA53;
    vpn = va[11:4];
    #1;
    pa = {ppn, va[3:0]};
    check_val("tlb_valid", {9'b0, valid}, 10'h001);
    check_val("tlb_pa", pa, 10'h2C3);

    // Async reset between edges restores contents immediately.
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    look("async_rst_a5", 8'hA5, 1'b0, 6'h00);
    look("async_rst_10", 8'h10, 1'b1, 6'h10);
    look("async_rst_ff", 8'hFF, 1'b0, 6'h00);

    // Writes are ignored while reset is asserted.
    wr_en    = 1'b1;
    wr_vpn   = 8'h20;
    wr_ppn   = 6'h03;
    wr_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    wr_en = 1'b0;
    look("wr_in_reset_20", 8'h20, 1'b1, 6'h20);

    // Release between edges; first edge write is accepted.
    rst_n    = 1'b1;
    wr_en    = 1'b1;
    wr_vpn   = 8'h30;
    wr_ppn   = 6'h01;
    wr_valid = 1'b1;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    look("first_edge_write_30", 8'h30, 1'b1, 6'h01);
    look("first_edge_other_31", 8'h31, 1'b1, 6'h31);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
